// File: rtl/vga_pkg.sv
// Shared field codes, control bit positions and RGB332 helpers for the sprite engine.
package vga_pkg;

    localparam logic [2:0] FLD_X      = 3'd0;
    localparam logic [2:0] FLD_Y      = 3'd1;
    localparam logic [2:0] FLD_W      = 3'd2;
    localparam logic [2:0] FLD_H      = 3'd3;
    localparam logic [2:0] FLD_CTRL   = 3'd4;
    localparam logic [2:0] FLD_BG     = 3'd5;
    localparam logic [2:0] FLD_COMMIT = 3'd6;

    localparam int unsigned CTRL_EN_BIT = 8;
    localparam int unsigned COL_W       = 8;

    localparam int unsigned RGB_R_HI = 7;
    localparam int unsigned RGB_R_LO = 5;
    localparam int unsigned RGB_G_HI = 4;
    localparam int unsigned RGB_G_LO = 2;
    localparam int unsigned RGB_B_HI = 1;
    localparam int unsigned RGB_B_LO = 0;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Split an RGB332 byte into its colour channels.
    function automatic rgb332_t to_rgb(input logic [COL_W-1:0] c);
        rgb332_t p;
        p.r = c[RGB_R_HI:RGB_R_LO];
        p.g = c[RGB_G_HI:RGB_G_LO];
        p.b = c[RGB_B_HI:RGB_B_LO];
        return p;
    endfunction

endpackage

// File: rtl/vga_obj_hit.sv
// Combinational rectangle hit test for one object; extents are widened by one bit so
// objects touching the right/bottom edge never wrap around to column/row 0.
module vga_obj_hit #(
    parameter int unsigned X_W = 10,
    parameter int unsigned Y_W = 10
) (
    input  logic [X_W-1:0] obj_x,
    input  logic [Y_W-1:0] obj_y,
    input  logic [X_W-1:0] obj_w,
    input  logic [Y_W-1:0] obj_h,
    input  logic           obj_en,
    input  logic [X_W-1:0] x_pos,
    input  logic [Y_W-1:0] y_pos,
    output logic           hit_c
);

    logic [X_W:0] x_end_c;
    logic [Y_W:0] y_end_c;
    logic         in_x_c;
    logic         in_y_c;

    assign x_end_c = {1'b0, obj_x} + {1'b0, obj_w};
    assign y_end_c = {1'b0, obj_y} + {1'b0, obj_h};

    // A zero width/height makes the end equal to the start, so nothing can hit.
    assign in_x_c = (x_pos >= obj_x) && ({1'b0, x_pos} < x_end_c);
    assign in_y_c = (y_pos >= obj_y) && ({1'b0, y_pos} < y_end_c);
    assign hit_c  = obj_en && in_x_c && in_y_c;

endmodule

// File: rtl/vga_sprite_engine.sv
// Bus-programmable rectangle renderer: double-buffered object registers committed at
// frame boundaries, two-stage hit/priority pipeline with sync kept aligned to pixels.
module vga_sprite_engine
    import vga_pkg::*;
#(
    parameter int unsigned NUM_OBJ     = 8,
    parameter int unsigned X_W         = 10,
    parameter int unsigned Y_W         = 10,
    parameter bit          AUTO_COMMIT = 1'b0,
    localparam int unsigned IDX_W      = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1,
    localparam int unsigned XY_W       = (X_W > Y_W) ? X_W : Y_W,
    localparam int unsigned D_W        = (XY_W > 9) ? XY_W : 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [IDX_W+2:0] addr,
    input  logic [D_W-1:0]   data_in,
    input  logic [X_W-1:0]   x_pos,
    input  logic [Y_W-1:0]   y_pos,
    input  logic             display_en,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic             frame_end,
    output logic             commit_pending,
    output logic             HS,
    output logic             VS,
    output logic [2:0]       red,
    output logic [2:0]       green,
    output logic [1:0]       blue
);

    logic [X_W-1:0]   sh_x   [NUM_OBJ];
    logic [Y_W-1:0]   sh_y   [NUM_OBJ];
    logic [X_W-1:0]   sh_w   [NUM_OBJ];
    logic [Y_W-1:0]   sh_h   [NUM_OBJ];
    logic [COL_W-1:0] sh_col [NUM_OBJ];
    logic [NUM_OBJ-1:0] sh_en;
    logic [COL_W-1:0] sh_bg;

    logic [X_W-1:0]   act_x   [NUM_OBJ];
    logic [Y_W-1:0]   act_y   [NUM_OBJ];
    logic [X_W-1:0]   act_w   [NUM_OBJ];
    logic [Y_W-1:0]   act_h   [NUM_OBJ];
    logic [COL_W-1:0] act_col [NUM_OBJ];
    logic [NUM_OBJ-1:0] act_en;
    logic [COL_W-1:0] act_bg;

    logic [IDX_W-1:0] wr_idx_c;
    logic [2:0]       wr_fld_c;
    logic             obj_wr_c;
    logic             glob_wr_c;
    logic             commit_wr_c;
    logic             do_commit_c;

    logic [NUM_OBJ-1:0] hit_c;
    logic [NUM_OBJ-1:0] hit_q;
    logic               de_q;
    logic               hs_q;
    logic               vs_q;
    logic [COL_W-1:0]   pix_col_c;
    rgb332_t            pix_q;

    assign wr_idx_c    = addr[IDX_W+2:3];
    assign wr_fld_c    = addr[2:0];
    assign obj_wr_c    = sel && (32'(wr_idx_c) < NUM_OBJ);
    assign glob_wr_c   = sel && (wr_idx_c == '0);
    assign commit_wr_c = glob_wr_c && (wr_fld_c == FLD_COMMIT);
    // A COMMIT write landing on frame_end is honoured in that same cycle.
    assign do_commit_c = frame_end && (commit_pending || commit_wr_c || AUTO_COMMIT);

    // Shadow register file written from the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_OBJ); i++) begin
                sh_x[i]   <= '0;
                sh_y[i]   <= '0;
                sh_w[i]   <= '0;
                sh_h[i]   <= '0;
                sh_col[i] <= '0;
            end
            sh_en <= '0;
            sh_bg <= '0;
        end else begin
            if (obj_wr_c) begin
                case (wr_fld_c)
                    FLD_X:    sh_x[wr_idx_c] <= data_in[X_W-1:0];
                    FLD_Y:    sh_y[wr_idx_c] <= data_in[Y_W-1:0];
                    FLD_W:    sh_w[wr_idx_c] <= data_in[X_W-1:0];
                    FLD_H:    sh_h[wr_idx_c] <= data_in[Y_W-1:0];
                    FLD_CTRL: begin
                        sh_en[wr_idx_c]  <= data_in[CTRL_EN_BIT];
                        sh_col[wr_idx_c] <= data_in[COL_W-1:0];
                    end
                    default: ;
                endcase
            end
            if (glob_wr_c && (wr_fld_c == FLD_BG)) begin
                sh_bg <= data_in[COL_W-1:0];
            end
        end
    end

    // Active registers copy the pre-write shadow contents at a committed frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_OBJ); i++) begin
                act_x[i]   <= '0;
                act_y[i]   <= '0;
                act_w[i]   <= '0;
                act_h[i]   <= '0;
                act_col[i] <= '0;
            end
            act_en <= '0;
            act_bg <= '0;
        end else if (do_commit_c) begin
            for (int i = 0; i < int'(NUM_OBJ); i++) begin
                act_x[i]   <= sh_x[i];
                act_y[i]   <= sh_y[i];
                act_w[i]   <= sh_w[i];
                act_h[i]   <= sh_h[i];
                act_col[i] <= sh_col[i];
            end
            act_en <= sh_en;
            act_bg <= sh_bg;
        end
    end

    // Pending-commit flag: set by a COMMIT write, cleared whenever a commit is applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_pending <= 1'b0;
        end else if (do_commit_c) begin
            commit_pending <= 1'b0;
        end else if (commit_wr_c) begin
            commit_pending <= 1'b1;
        end
    end

    for (genvar g = 0; g < int'(NUM_OBJ); g++) begin : g_hit
        vga_obj_hit #(
            .X_W (X_W),
            .Y_W (Y_W)
        ) u_hit (
            .obj_x  (act_x[g]),
            .obj_y  (act_y[g]),
            .obj_w  (act_w[g]),
            .obj_h  (act_h[g]),
            .obj_en (act_en[g]),
            .x_pos  (x_pos),
            .y_pos  (y_pos),
            .hit_c  (hit_c[g])
        );
    end

    // Stage 1: per-object hit vector plus video qualifiers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= '0;
            de_q  <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            hit_q <= hit_c;
            de_q  <= display_en;
            hs_q  <= hs_in;
            vs_q  <= vs_in;
        end
    end

    // Priority resolve: lowest-index hit wins, otherwise background; blanking forces black.
    always_comb begin
        pix_col_c = act_bg;
        for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                pix_col_c = act_col[i];
            end
        end
        if (!de_q) begin
            pix_col_c = '0;
        end
    end

    // Stage 2: registered pixel and sync outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q <= '0;
            HS    <= 1'b0;
            VS    <= 1'b0;
        end else begin
            pix_q <= to_rgb(pix_col_c);
            HS    <= hs_q;
            VS    <= vs_q;
        end
    end

    assign red   = pix_q.r;
    assign green = pix_q.g;
    assign blue  = pix_q.b;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Self-checking bench for vga_sprite_engine with a frame-level behavioural model.
module tb_vga_sprite_engine;

    localparam int NUM_OBJ = 8;
    localparam int X_W     = 10;
    localparam int Y_W     = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic [5:0] addr;
    logic [9:0] data_in;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       display_en, hs_in, vs_in, frame_end;
    logic       commit_pending, HS, VS;
    logic [2:0] red, green;
    logic [1:0] blue;

    always #5 clk = ~clk;

    vga_sprite_engine #(
        .NUM_OBJ     (NUM_OBJ),
        .X_W         (X_W),
        .Y_W         (Y_W),
        .AUTO_COMMIT (1'b0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sel            (sel),
        .addr           (addr),
        .data_in        (data_in),
        .x_pos          (x_pos),
        .y_pos          (y_pos),
        .display_en     (display_en),
        .hs_in          (hs_in),
        .vs_in          (vs_in),
        .frame_end      (frame_end),
        .commit_pending (commit_pending),
        .HS             (HS),
        .VS             (VS),
        .red            (red),
        .green          (green),
        .blue           (blue)
    );

    // Behavioural model: shadow/active object tables and a two-cycle output delay.
    int sh_x[NUM_OBJ], sh_y[NUM_OBJ], sh_w[NUM_OBJ], sh_h[NUM_OBJ], sh_col[NUM_OBJ];
    bit sh_en[NUM_OBJ];
    int act_x[NUM_OBJ], act_y[NUM_OBJ], act_w[NUM_OBJ], act_h[NUM_OBJ], act_col[NUM_OBJ];
    bit act_en[NUM_OBJ];
    int sh_bg, act_bg;
    bit pend;

    logic [7:0] p_col, e_col;
    logic       p_hs, p_vs, e_hs, e_vs;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [7:0] ref_colour(input int x, input int y, input bit de);
        if (!de) return 8'h00;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (act_en[i] && x >= act_x[i] && x < act_x[i] + act_w[i] &&
                y >= act_y[i] && y < act_y[i] + act_h[i])
                return 8'(act_col[i]);
        end
        return 8'(act_bg);
    endfunction

    function automatic logic [5:0] ad(input int idx, input int fld);
        return {3'(idx), 3'(fld)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_OBJ; i++) begin
            sh_x[i] = 0; sh_y[i] = 0; sh_w[i] = 0; sh_h[i] = 0; sh_col[i] = 0; sh_en[i] = 0;
            act_x[i] = 0; act_y[i] = 0; act_w[i] = 0; act_h[i] = 0; act_col[i] = 0; act_en[i] = 0;
        end
        sh_bg = 0; act_bg = 0; pend = 0;
        p_col = 0; p_hs = 0; p_vs = 0; e_col = 0; e_hs = 0; e_vs = 0;
    endtask

    // One clock: drive inputs, advance model across the edge, settle before checking.
    task automatic cyc(input bit r, input bit s, input logic [5:0] a, input logic [9:0] d,
                       input int x, input int y, input bit de, input bit h, input bit v,
                       input bit fe);
        int idx, fld;
        bit cw, doc;
        @(negedge clk);
        rst = r; sel = s; addr = a; data_in = d;
        x_pos = 10'(x); y_pos = 10'(y);
        display_en = de; hs_in = h; vs_in = v; frame_end = fe;
        @(posedge clk);
        if (r) begin
            model_clear();
        end else begin
            idx = int'(a[5:3]);
            fld = int'(a[2:0]);
            e_col = p_col; e_hs = p_hs; e_vs = p_vs;
            p_col = ref_colour(x, y, de);
            p_hs = h; p_vs = v;
            cw  = s && idx == 0 && fld == 6;
            doc = fe && (pend || cw);
            if (doc) begin
                for (int i = 0; i < NUM_OBJ; i++) begin
                    act_x[i] = sh_x[i]; act_y[i] = sh_y[i]; act_w[i] = sh_w[i];
                    act_h[i] = sh_h[i]; act_col[i] = sh_col[i]; act_en[i] = sh_en[i];
                end
                act_bg = sh_bg;
            end
            if (s && idx < NUM_OBJ) begin
                case (fld)
                    0: sh_x[idx] = int'(d);
                    1: sh_y[idx] = int'(d);
                    2: sh_w[idx] = int'(d);
                    3: sh_h[idx] = int'(d);
                    4: begin sh_en[idx] = d[8]; sh_col[idx] = int'(d[7:0]); end
                    5: if (idx == 0) sh_bg = int'(d[7:0]);
                    default: ;
                endcase
            end
            if (doc) pend = 0;
            else if (cw) pend = 1;
        end
        #1;
    endtask

    task automatic wr(input int idx, input int fld, input int d);
        cyc(0, 1, ad(idx, fld), 10'(d), 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fend();
        cyc(0, 0, 6'd0, 10'd0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic pix(input int x, input int y, input bit de);
        cyc(0, 0, 6'd0, 10'd0, x, y, de, 0, 0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, 6'd0, 10'd0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({HS, VS, red, green, blue, commit_pending} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required 0", {HS, VS, red, green, blue, commit_pending});
        end
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, 6'd0, 10'd0, $urandom_range(0, 1023), $urandom_range(0, 1023), 1,
                1'($urandom), 1'($urandom), 0);
            n_cmp++;
            if ({HS, VS, red, green, blue} !== {e_hs, e_vs, e_col} || e_col !== 8'h00) begin
                n_bad++;
                $display("FAIL empty_frame: got %b required %b", {HS, VS, red, green, blue}, {e_hs, e_vs, e_col});
            end
        end
    endtask

    task automatic test_single_object();
        wr(0, 5, 8'h25);
        wr(0, 0, 100); wr(0, 1, 50); wr(0, 2, 10); wr(0, 3, 4); wr(0, 4, 10'h1E0);
        wr(0, 6, 0);
        n_cmp++;
        if (commit_pending !== 1'b1) begin
            n_bad++; $display("FAIL pending_set: got %b required 1", commit_pending);
        end
        fend();
        n_cmp++;
        if (commit_pending !== 1'b0) begin
            n_bad++; $display("FAIL pending_clear: got %b required 0", commit_pending);
        end
        for (int y = 48; y <= 55; y++) begin
            for (int x = 97; x <= 112; x++) begin
                pix(x, y, 1);
                n_cmp++;
                if ({red, green, blue} !== e_col) begin
                    n_bad++; $display("FAIL obj0_scan: got %h required %h", {red, green, blue}, e_col);
                end
            end
        end
        pix(109, 53, 1); pix(0, 0, 0);
        n_cmp++;
        if (red !== 3'd7 || {red, green, blue} !== 8'hE0) begin
            n_bad++; $display("FAIL obj0_corner: got %h required e0", {red, green, blue});
        end
        pix(110, 51, 1); pix(0, 0, 0);
        n_cmp++;
        if ({red, green, blue} !== 8'h25) begin
            n_bad++; $display("FAIL obj0_right_edge: got %h required 25", {red, green, blue});
        end
    endtask

    task automatic test_priority();
        wr(3, 0, 100); wr(3, 1, 50); wr(3, 2, 10); wr(3, 3, 4); wr(3, 4, 10'h103);
        wr(0, 6, 0); fend();
        pix(105, 51, 1); pix(0, 0, 0);
        n_cmp++;
        if ({red, green, blue} !== 8'hE0) begin
            n_bad++; $display("FAIL prio_obj0_wins: got %h required e0", {red, green, blue});
        end
        wr(0, 4, 10'h0E0); wr(0, 6, 0); fend();
        pix(105, 51, 1); pix(0, 0, 0);
        n_cmp++;
        if ({red, green, blue} !== 8'h03 || e_col !== 8'h03) begin
            n_bad++; $display("FAIL prio_obj3_shows: got %h required 03", {red, green, blue});
        end
    endtask

    task automatic test_shadow_hold();
        wr(0, 4, 10'h1E0); wr(0, 0, 200);
        fend(); fend();
        n_cmp++;
        if (commit_pending !== 1'b0) begin
            n_bad++; $display("FAIL hold_pending: got %b required 0", commit_pending);
        end
        pix(105, 51, 1); pix(205, 51, 1);
        n_cmp++;
        if ({red, green, blue} !== 8'h03) begin
            n_bad++; $display("FAIL hold_old_pos: got %h required 03", {red, green, blue});
        end
        pix(0, 0, 0);
        n_cmp++;
        if ({red, green, blue} !== 8'h25) begin
            n_bad++; $display("FAIL hold_new_pos_bg: got %h required 25", {red, green, blue});
        end
        wr(0, 6, 0); fend();
        pix(205, 51, 1); pix(105, 51, 1);
        n_cmp++;
        if ({red, green, blue} !== 8'hE0) begin
            n_bad++; $display("FAIL moved_to_200: got %h required e0", {red, green, blue});
        end
        pix(0, 0, 0);
        n_cmp++;
        if ({red, green, blue} !== 8'h03) begin
            n_bad++; $display("FAIL old_spot_obj3: got %h required 03", {red, green, blue});
        end
    endtask

    task automatic test_coincident();
        wr(0, 6, 0);
        cyc(0, 1, ad(0, 0), 10'd300, 0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (commit_pending !== 1'b0) begin
            n_bad++; $display("FAIL coinc_write_pending: got %b required 0", commit_pending);
        end
        pix(205, 51, 1); pix(305, 51, 1);
        n_cmp++;
        if ({red, green, blue} !== 8'hE0) begin
            n_bad++; $display("FAIL coinc_keeps_old_x: got %h required e0", {red, green, blue});
        end
        pix(0, 0, 0);
        n_cmp++;
        if ({red, green, blue} !== 8'h25) begin
            n_bad++; $display("FAIL coinc_new_x_waits: got %h required 25", {red, green, blue});
        end
        cyc(0, 1, ad(0, 6), 10'd0, 0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (commit_pending !== 1'b0) begin
            n_bad++; $display("FAIL coinc_commit_pending: got %b required 0", commit_pending);
        end
        pix(305, 51, 1); pix(0, 0, 0);
        n_cmp++;
        if ({red, green, blue} !== 8'hE0) begin
            n_bad++; $display("FAIL coinc_commit_applied: got %h required e0", {red, green, blue});
        end
    endtask

    task automatic test_edges();
        wr(1, 0, 1020); wr(1, 1, 0); wr(1, 2, 10); wr(1, 3, 2); wr(1, 4, 10'h11C);
        wr(2, 0, 10); wr(2, 1, 10); wr(2, 2, 0); wr(2, 3, 5); wr(2, 4, 10'h1FF);
        wr(0, 6, 0); fend();
        for (int y = 0; y <= 2; y++) begin
            for (int k = 0; k < 14; k++) begin
                pix((k < 8) ? 1016 + k : k - 8, y, 1);
                n_cmp++;
                if ({red, green, blue} !== e_col) begin
                    n_bad++; $display("FAIL right_edge_scan: got %h required %h", {red, green, blue}, e_col);
                end
            end
        end
        pix(1023, 1, 1); pix(0, 1, 1);
        n_cmp++;
        if ({red, green, blue} !== 8'h1C) begin
            n_bad++; $display("FAIL hit_1023: got %h required 1c", {red, green, blue});
        end
        pix(0, 0, 0);
        n_cmp++;
        if ({red, green, blue} !== 8'h25) begin
            n_bad++; $display("FAIL no_wrap_to_0: got %h required 25", {red, green, blue});
        end
        for (int x = 8; x <= 14; x++) begin
            pix(x, 12, 1);
            n_cmp++;
            if ({red, green, blue} !== e_col || (x > 9 && e_col !== 8'h25)) begin
                n_bad++; $display("FAIL zero_width: got %h required %h", {red, green, blue}, e_col);
            end
        end
        pix(1021, 1, 0); pix(0, 0, 0);
        n_cmp++;
        if ({red, green, blue} !== 8'h00) begin
            n_bad++; $display("FAIL blanked_in_obj: got %h required 00", {red, green, blue});
        end
        cyc(0, 0, 6'd0, 10'd0, 1021, 0, 1, 1, 1, 0);
        cyc(1, 0, 6'd0, 10'd0, 1021, 0, 1, 1, 1, 0);
        n_cmp++;
        if ({HS, VS, red, green, blue, commit_pending} !== 11'd0) begin
            n_bad++; $display("FAIL mid_line_reset: got %b required 0", {HS, VS, red, green, blue, commit_pending});
        end
        for (int i = 0; i < 3; i++) begin
            pix(1021, 0, 1);
            n_cmp++;
            if ({red, green, blue} !== 8'h00 || {red, green, blue} !== e_col) begin
                n_bad++; $display("FAIL after_reset_bg0: got %h required 00", {red, green, blue});
            end
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                wr(i, 0, (i == 7) ? $urandom_range(1000, 1023) : $urandom_range(0, 60));
                wr(i, 1, $urandom_range(0, 30));
                wr(i, 2, $urandom_range(0, 20));
                wr(i, 3, $urandom_range(0, 10));
                wr(i, 4, $urandom_range(0, 511));
            end
            wr(0, 5, $urandom_range(0, 255));
            wr(0, 6, 0); fend();
            for (int n = 0; n < 150; n++) begin
                bit s;
                s = ($urandom_range(0, 15) == 0);
                cyc(0, s, ad($urandom_range(0, 7), $urandom_range(0, 4)), 10'($urandom),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 80),
                    $urandom_range(0, 40), ($urandom_range(0, 3) != 0),
                    1'($urandom), 1'($urandom), 0);
                n_cmp++;
                if ({HS, VS, red, green, blue, commit_pending} !== {e_hs, e_vs, e_col, pend}) begin
                    n_bad++;
                    $display("FAIL random_pixel: got %b required %b",
                             {HS, VS, red, green, blue, commit_pending}, {e_hs, e_vs, e_col, pend});
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; addr = '0; data_in = '0; x_pos = '0; y_pos = '0;
        display_en = 1'b0; hs_in = 1'b0; vs_in = 1'b0; frame_end = 1'b0;
        model_clear();
        test_reset();
        test_single_object();
        test_priority();
        test_shadow_hold();
        test_coincident();
        test_edges();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
